// File: rtl/dbi_decoder.sv
// Receive-side DBI decoder: restores inverted bytes into a 2-entry FIFO and
// counts inverted beats. Define DBI_PARITY_CHK_EN to add in_par/par_err checking.
module dbi_decoder #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_dbi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  input  logic             clr_stats,
`ifdef DBI_PARITY_CHK_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic [CNT_W-1:0] inv_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          accept;
  logic          pop;

  function automatic logic [DW-1:0] dbi_restore(input logic [DW-1:0] d, input logic inv);
    return inv ? ~d : d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_ONE;
  endfunction

  // Handshake flags depend only on registered occupancy, never on in_*.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= dbi_restore(in_data, in_dbi);
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_count <= '0;
    end else if (clr_stats) begin
      inv_count <= '0;
    end else if (accept && in_dbi) begin
      inv_count <= sat_inc(inv_count);
    end
  end

`ifdef DBI_PARITY_CHK_EN
  // Sticky error; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (accept && ((^{in_dbi, in_data}) != in_par)) begin
      par_err <= 1'b1;
    end else if (clr_stats) begin
      par_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dbi_decoder.sv
// Scoreboard bench for dbi_decoder (CNT_W=4 so saturation is reachable).
// Parity checks are built only when DBI_PARITY_CHK_EN is defined.
module tb_dbi_decoder;

  localparam int DW    = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             in_dbi = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] inv_count;
`ifdef DBI_PARITY_CHK_EN
  logic             in_par = 1'b0;
  logic             par_err;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random
  logic [7:0]  exp_q[$];
  int          occ = 0;
  int          exp_inv = 0;

  dbi_decoder #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dbi    (in_dbi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .clr_stats (clr_stats),
`ifdef DBI_PARITY_CHK_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .inv_count (inv_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: occupancy/statistics model plus in-order scoreboard.
  always @(negedge clk) begin
    logic acc, pp;
    logic [7:0] e;
    if (!rst_n) begin
      occ = 0;
      exp_inv = 0;
      exp_q.delete();
    end else begin
      chk("in_ready", 32'(in_ready), 32'(occ != 2));
      chk("out_valid", 32'(out_valid), 32'(occ != 0));
      chk("inv_count", 32'(inv_count), 32'(exp_inv));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
      end
      acc = in_valid && (occ != 2);
      pp  = out_ready && (occ != 0);
      occ = occ + int'(acc) - int'(pp);
      if (clr_stats) exp_inv = 0;
      else if (acc && in_dbi && exp_inv != 15) exp_inv++;
    end
  end

  task automatic send(input logic [7:0] d, input logic b, input logic [7:0] exp, input logic par_ok);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_dbi   = b;
`ifdef DBI_PARITY_CHK_EN
    in_par   = par_ok ? ^{b, d} : ~^{b, d};
`endif
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        break;
      end
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       b;
    int         c0;

    tick(3);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_inv_count", 32'(inv_count), 32'd0);
`ifdef DBI_PARITY_CHK_EN
    chk("rst_par_err", 32'(par_err), 32'd0);
`endif
    tick(2);

    // Decode with one-cycle latency
    rdy_mode = 1;
    tick(2);
    send(8'hA5, 1'b0, 8'hA5, 1'b1);
    chk("lat_valid0", 32'(out_valid), 32'd1);
    chk("lat_data0", 32'(out_data), 32'hA5);
    send(8'hA5, 1'b1, 8'h5A, 1'b1);
    chk("lat_valid1", 32'(out_valid), 32'd1);
    chk("lat_data1", 32'(out_data), 32'h5A);
    tick(2);
    chk("decode_inv_count", 32'(inv_count), 32'd1);

    // Backpressure: third beat held by the sender until space frees
    rdy_mode = 0;
    tick(2);
    send(8'h01, 1'b0, 8'h01, 1'b1);
    send(8'h02, 1'b0, 8'h02, 1'b1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(8'hFC, 1'b1, 8'h03, 1'b1);
      begin tick(4); rdy_mode = 1; end
    join
    tick(4);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back throughput with the consumer always ready
    c0 = cyc;
    for (int i = 0; i < 20; i++) send(8'(i * 7), 1'b0, 8'(i * 7), 1'b1);
    chk("throughput_cycles", 32'(cyc - c0), 32'd20);
    tick(3);

    // Random streaming
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) tick(1);
      d = 8'($urandom);
      b = 1'($urandom);
      send(d, b, b ? ~d : d, 1'b1);
    end
    rdy_mode = 1;
    tick(6);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Saturation and clear priority
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    chk("clr_inv_count", 32'(inv_count), 32'd0);
    for (int i = 0; i < 20; i++) send(8'h0F, 1'b1, 8'hF0, 1'b1);
    chk("sat_inv_count", 32'(inv_count), 32'd15);
    tick(3);
    clr_stats = 1'b1;
    send(8'h33, 1'b1, 8'hCC, 1'b1);
    clr_stats = 1'b0;
    chk("clr_wins_inv_count", 32'(inv_count), 32'd0);
    tick(3);

`ifdef DBI_PARITY_CHK_EN
    send(8'h03, 1'b0, 8'h03, 1'b0);
    chk("par_err_set", 32'(par_err), 32'd1);
    tick(2);
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    chk("par_err_clr", 32'(par_err), 32'd0);
    clr_stats = 1'b1;
    send(8'h81, 1'b1, 8'h7E, 1'b0);
    clr_stats = 1'b0;
    chk("par_set_wins", 32'(par_err), 32'd1);
    tick(3);
`endif

    // Asynchronous reset while the FIFO holds data
    rdy_mode = 0;
    tick(2);
    send(8'h11, 1'b1, 8'hEE, 1'b1);
    send(8'h22, 1'b0, 8'h22, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_data", 32'(out_data), 32'h00);
    chk("mid_rst_inv_count", 32'(inv_count), 32'd0);
    tick(2);
    rst_n = 1'b1;
    rdy_mode = 1;
    tick(3);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    send(8'h5C, 1'b0, 8'h5C, 1'b1);
    tick(3);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
